width_pack: RTL

Narrow-to-wide packer that assembles AMOUNT consecutive IWIDTH-bit fragments into one OWIDTH-bit word. The fragment order matches the wide-to-narrow splitter: fragment 0 goes to the LSBs. It sits downstream of the fragment stream, for example the PE result path, and feeds wide buffer writes. Valid/ready on both sides; a double-buffered output sustains one fragment per cycle with no bubbles.

---
 rtl/width_pack_pkg.sv | 19 +
 rtl/width_pack_cnt.sv | 88 ++++++++
 rtl/width_pack.sv | 121 ++++++++++++
 3 files changed

// File: rtl/width_pack_pkg.sv
// width_pack_pkg: shared defaults and helpers for the narrow-to-wide packer.
// Holds the default 36/288 datapath widths and the ceil-log2 helper used to
// size the fragment counter.
package width_pack_pkg;

    localparam int PACK_IWIDTH_DEF = 36;
    localparam int PACK_OWIDTH_DEF = 288;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/width_pack_cnt.sv
// pack_cnt: fill counter for width_pack.
// Tracks how many fragments sit in the assembly register, wraps after the
// last slice, flags the completing slot and, when WIDTH_PACK_FLUSH_EN is
// defined, holds the flush-pending flag.
module pack_cnt
    import width_pack_pkg::*;
#(
    parameter  int AMOUNT    = 8,
    localparam int CNT_WIDTH = clog2_min1(AMOUNT)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 accept,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 last
`ifdef WIDTH_PACK_FLUSH_EN
    ,
    input  logic                 flush,
    input  logic                 clear,
    output logic                 flush_pend
`endif
);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(AMOUNT - 1);

    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] cnt_inc_s;
    logic [CNT_WIDTH-1:0] cnt_nxt_s;

    // Next count: wrapping increment on accept, otherwise hold.
    always_comb begin
        cnt_inc_s = cnt_r;
        cnt_nxt_s = cnt_r;
        if (cnt_r == LAST_IDX) begin
            cnt_inc_s = '0;
        end else begin
            cnt_inc_s = cnt_r + 1'b1;
        end
        if (accept) begin
            cnt_nxt_s = cnt_inc_s;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

`ifdef WIDTH_PACK_FLUSH_EN
    logic flush_pend_r;

    // Fill counter; an emitted partial word restarts assembly at slice 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    // Flush request is remembered only if data remains after this cycle's accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            flush_pend_r <= 1'b0;
        end else if (clear) begin
            flush_pend_r <= 1'b0;
        end else if (flush && (cnt_nxt_s != '0)) begin
            flush_pend_r <= 1'b1;
        end else begin
            flush_pend_r <= flush_pend_r;
        end
    end

    assign flush_pend = flush_pend_r;
`else
    // Fill counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end
`endif

    assign cnt  = cnt_r;
    assign last = (cnt_r == LAST_IDX);

endmodule

// File: rtl/width_pack.sv
// width_pack: narrow-to-wide packer. AMOUNT consecutive IWIDTH-bit fragments
// are assembled into one OWIDTH-bit word, fragment 0 in the LSBs. The
// assembly register plus the output register let a new word start while the
// previous one waits, so a fragment per cycle flows without bubbles.
// Optional feature macro: WIDTH_PACK_FLUSH_EN (adds flush / dout_num).
module width_pack
    import width_pack_pkg::*;
#(
    parameter  int IWIDTH    = PACK_IWIDTH_DEF,
    parameter  int OWIDTH    = PACK_OWIDTH_DEF,
    localparam int AMOUNT    = OWIDTH / IWIDTH,
    localparam int CNT_WIDTH = clog2_min1(AMOUNT)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [IWIDTH-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [OWIDTH-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready
`ifdef WIDTH_PACK_FLUSH_EN
    ,
    input  logic              flush,
    output logic [CNT_WIDTH:0] dout_num
`endif
);

    logic [OWIDTH-1:0]    asm_r;
    logic [OWIDTH-1:0]    asm_ins_s;
    logic [OWIDTH-1:0]    dout_r;
    logic                 dout_valid_r;
    logic                 out_free_s;
    logic                 din_ready_s;
    logic                 accept_s;
    logic                 complete_s;
    logic                 last_s;
    logic [CNT_WIDTH-1:0] cnt_s;

`ifdef WIDTH_PACK_FLUSH_EN
    logic                 pend_s;
    logic                 flush_go_s;
    logic [CNT_WIDTH:0]   dout_num_r;
`endif

`ifdef WIDTH_PACK_FLUSH_EN
    pack_cnt #(.AMOUNT(AMOUNT)) u_cnt (
        .clk        (clk),
        .resetn     (resetn),
        .accept     (accept_s),
        .cnt        (cnt_s),
        .last       (last_s),
        .flush      (flush),
        .clear      (flush_go_s),
        .flush_pend (pend_s)
    );
`else
    pack_cnt #(.AMOUNT(AMOUNT)) u_cnt (
        .clk    (clk),
        .resetn (resetn),
        .accept (accept_s),
        .cnt    (cnt_s),
        .last   (last_s)
    );
`endif

    // Handshake: only the completing fragment can be stalled by a full output.
    always_comb begin
        out_free_s  = ~dout_valid_r | dout_ready;
`ifdef WIDTH_PACK_FLUSH_EN
        din_ready_s = ~(last_s & ~out_free_s) & ~pend_s;
        flush_go_s  = pend_s & out_free_s;
`else
        din_ready_s = ~(last_s & ~out_free_s);
`endif
        accept_s    = din_valid & din_ready_s;
        complete_s  = accept_s & last_s;
    end

    // Assembly word with the incoming fragment dropped into its slice.
    always_comb begin
        asm_ins_s = asm_r;
        asm_ins_s[int'(cnt_s) * IWIDTH +: IWIDTH] = din;
    end

    // Datapath: slice writes, word hand-off to the output register, drain.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            asm_r        <= '0;
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
`ifdef WIDTH_PACK_FLUSH_EN
            dout_num_r   <= '0;
`endif
        end else if (complete_s) begin
            dout_r       <= asm_ins_s;
            asm_r        <= '0;
            dout_valid_r <= 1'b1;
`ifdef WIDTH_PACK_FLUSH_EN
            dout_num_r   <= (CNT_WIDTH + 1)'(AMOUNT);
        end else if (flush_go_s) begin
            dout_r       <= asm_r;
            asm_r        <= '0;
            dout_valid_r <= 1'b1;
            dout_num_r   <= {1'b0, cnt_s};
`endif
        end else begin
            asm_r        <= accept_s ? asm_ins_s : asm_r;
            dout_r       <= dout_r;
            dout_valid_r <= dout_ready ? 1'b0 : dout_valid_r;
        end
    end

    assign din_ready  = din_ready_s;
    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
`ifdef WIDTH_PACK_FLUSH_EN
    assign dout_num   = dout_num_r;
`endif

endmodule
